// File: rtl/rvfi_pkt_serializer.sv
// RVFI retirement packet serializer: buffers retirements in a small FIFO
// and streams each as a 24-byte little-endian packet over a byte handshake.
module rvfi_pkt_serializer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  input  logic [31:0] ret_nxt_pc,
  input  logic [31:0] ret_instr,
  input  logic [31:0] ret_rd_val,
  input  logic [31:0] ret_mem_addr,
  input  logic [4:0]  ret_rd,
  input  logic        ret_trap,
  input  logic [3:0]  ret_mem_rmask,
  input  logic [3:0]  ret_mem_wmask,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic        fifo_full,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q, state_d;
  logic [183:0]    mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      idx_q, idx_d;
  logic [7:0]      seq_q, drop_q, drop_d;
  logic            full_q, ovf_q;
  logic            pop, push, drop;
  logic [183:0]    entry;
  logic [191:0]    pkt;

  // Entry holds every byte after the 0xA5 sync byte, in wire order.
  assign entry = {seq_q, ret_mem_wmask, ret_mem_rmask,
                  ret_trap, 2'b00, ret_rd, ret_mem_addr,
                  ret_rd_val, ret_instr, ret_nxt_pc, ret_pc};
  assign pkt   = {mem_q[rptr_q], 8'hA5};

  assign pop  = (state_q == SEND) && tx_ready
             && (idx_q == 5'd23);
  assign push = ret_valid
             && ((cnt_q != CW'(DEPTH)) || pop);
  assign drop = ret_valid && !push;

  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);
  assign drop_d = (drop && drop_q != 8'hFF)
                ? drop_q + 8'd1 : drop_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d = SEND;
          idx_d   = 5'd0;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == 5'd23) begin
            idx_d   = 5'd0;
            state_d = (cnt_d != '0) ? SEND : IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_q + AW'(push);
      rptr_q  <= rptr_q + AW'(pop);
      full_q  <= (cnt_d == CW'(DEPTH));
      drop_q  <= drop_d;
      if (ret_valid) seq_q <= seq_q + 8'd1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= entry;
  end

  assign tx_valid  = (state_q == SEND);
  assign tx_data   = tx_valid ? pkt[{idx_q, 3'b000} +: 8] : 8'h00;
  assign tx_last   = tx_valid && (idx_q == 5'd23);
  assign fifo_full = full_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_rvfi_pkt_serializer.sv
// Self-checking bench for rvfi_pkt_serializer against a queue-based
// packet model plus literal byte expectations.
module tb_rvfi_pkt_serializer;

  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic        ret_valid = 0;
  logic [31:0] ret_pc = 0, ret_nxt_pc = 0, ret_instr = 0;
  logic [31:0] ret_rd_val = 0, ret_mem_addr = 0;
  logic [4:0]  ret_rd = 0;
  logic        ret_trap = 0;
  logic [3:0]  ret_mem_rmask = 0, ret_mem_wmask = 0;
  logic        tx_valid, tx_ready = 0, tx_last;
  logic [7:0]  tx_data;
  logic        fifo_full, overflow;
  logic [7:0]  drop_cnt;

  rvfi_pkt_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ret_valid(ret_valid),
    .ret_pc(ret_pc), .ret_nxt_pc(ret_nxt_pc),
    .ret_instr(ret_instr), .ret_rd_val(ret_rd_val),
    .ret_mem_addr(ret_mem_addr), .ret_rd(ret_rd),
    .ret_trap(ret_trap),
    .ret_mem_rmask(ret_mem_rmask),
    .ret_mem_wmask(ret_mem_wmask),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last),
    .fifo_full(fifo_full), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  typedef logic [7:0] pkt_t [24];

  pkt_t       mq[$];
  int         midx = 0;
  logic [7:0] mseq = 0;
  logic [7:0] mdrop = 0;
  logic       movf = 0;
  logic [7:0] sent[$];
  logic       lastq[$];

  function automatic pkt_t mkpkt(logic [7:0] s);
    pkt_t p;
    p[0] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      p[1+i]  = ret_pc[8*i +: 8];
      p[5+i]  = ret_nxt_pc[8*i +: 8];
      p[9+i]  = ret_instr[8*i +: 8];
      p[13+i] = ret_rd_val[8*i +: 8];
      p[17+i] = ret_mem_addr[8*i +: 8];
    end
    p[21] = {ret_trap, 2'b00, ret_rd};
    p[22] = {ret_mem_wmask, ret_mem_rmask};
    p[23] = s;
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      midx  = 0;
      mseq  = 0;
      mdrop = 0;
      movf  = 0;
    end else begin
      int  sz;
      bit  mpop;
      sz   = mq.size();
      mpop = 0;
      if (tx_valid && tx_ready) begin
        sent.push_back(tx_data);
        lastq.push_back(tx_last);
        if (midx == 23) begin
          mpop = 1;
          midx = 0;
          if (mq.size() > 0) void'(mq.pop_front());
        end else begin
          midx++;
        end
      end
      if (ret_valid) begin
        if (sz < DEPTH || mpop) mq.push_back(mkpkt(mseq));
        else begin
          movf = 1;
          if (mdrop != 8'hFF) mdrop = mdrop + 8'd1;
        end
        mseq = mseq + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid) begin
        if (mq.size() == 0) chk("valid_when_model_empty", 1, 0);
        else begin
          chk("tx_data", tx_data, mq[0][midx]);
          chk("tx_last", tx_last, 32'(midx == 23));
        end
      end else begin
        chk("idle_data", tx_data, 0);
        chk("idle_last", tx_last, 0);
      end
      chk("fifo_full", fifo_full, 32'(mq.size() == DEPTH));
      chk("overflow", overflow, movf);
      chk("drop_cnt", drop_cnt, mdrop);
    end
  end

  task automatic do_reset();
    ret_valid = 0;
    tx_ready  = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic retire(logic [31:0] pc, logic [31:0] ins,
                        logic [31:0] rv, logic [4:0] rd);
    ret_pc        = pc;
    ret_nxt_pc    = pc + 4;
    ret_instr     = ins;
    ret_rd_val    = rv;
    ret_mem_addr  = pc ^ 32'h1234_5678;
    ret_rd        = rd;
    ret_trap      = pc[2];
    ret_mem_rmask = pc[3:0];
    ret_mem_wmask = pc[7:4];
    ret_valid     = 1;
    @(negedge clk);
    ret_valid     = 0;
  endtask

  task automatic drain();
    int n = 0;
    tx_ready = 1;
    while ((mq.size() != 0 || tx_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 3000), 1);
  endtask

  initial begin
    int base;
    int n;
    rst = 1;
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst = 0;

    // single retire, streaming
    tx_ready = 1;
    base = sent.size();
    ret_mem_addr = 0;
    ret_pc = 32'h8000_0000; ret_nxt_pc = 32'h8000_0004;
    ret_instr = 32'h0050_0093; ret_rd_val = 5; ret_rd = 1;
    ret_trap = 0; ret_mem_rmask = 0; ret_mem_wmask = 0;
    ret_valid = 1;
    @(negedge clk);
    ret_valid = 0;
    drain();
    chk("t1_len", sent.size() - base, 24);
    chk("t1_b0", sent[base], 8'hA5);
    chk("t1_b1", sent[base+1], 8'h00);
    chk("t1_b2", sent[base+2], 8'h00);
    chk("t1_b3", sent[base+3], 8'h00);
    chk("t1_b4", sent[base+4], 8'h80);
    chk("t1_b9", sent[base+9], 8'h93);
    chk("t1_b13", sent[base+13], 8'h05);
    chk("t1_b21", sent[base+21], 8'h01);
    chk("t1_b23", sent[base+23], 8'h00);
    chk("t1_last23", lastq[base+23], 1);
    chk("t1_last22", lastq[base+22], 0);

    // ready toggling 1,0,0,1
    do_reset();
    base = sent.size();
    retire(32'h0000_1000, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd31);
    n = 0;
    while ((mq.size() != 0 || tx_valid) && n < 500) begin
      tx_ready = (n % 4 == 0) || (n % 4 == 3);
      @(negedge clk);
      n++;
    end
    chk("t2_timeout", 32'(n < 500), 1);
    chk("t2_len", sent.size() - base, 24);
    chk("t2_b0", sent[base], 8'hA5);
    chk("t2_b9", sent[base+9], 8'hEF);
    chk("t2_b21", sent[base+21], 8'h1F);

    // fill to full with ready low, two drops
    do_reset();
    base = sent.size();
    for (int i = 0; i < 6; i++) begin
      retire(32'h100 * i, i, i, 5'(i));
      if (i == 3) chk("t3_full_after4", fifo_full, 1);
    end
    chk("t3_overflow", overflow, 1);
    chk("t3_drop2", drop_cnt, 2);
    drain();
    chk("t3_len", sent.size() - base, 96);
    for (int k = 0; k < 4; k++)
      chk("t3_seq", sent[base + 23 + 24*k], k);

    // retire coincident with byte-23 pop while full
    do_reset();
    for (int i = 0; i < 4; i++) retire(32'h40 * i, 0, 0, 0);
    tx_ready = 1;
    n = 0;
    while (!tx_last && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_last", tx_last, 1);
    chk("t4_full_before", fifo_full, 1);
    retire(32'h5000, 1, 2, 3);
    chk("t4_drop_unchanged", drop_cnt, 0);
    chk("t4_full_kept", fifo_full, 1);
    chk("t4_no_overflow", overflow, 0);
    drain();

    // drop saturation and seq wrap
    do_reset();
    for (int i = 0; i < 4; i++) retire(32'h10 * i, 0, 0, 0);
    for (int i = 0; i < 250; i++) retire(32'h20, 0, 0, 0);
    chk("t5_drop250", drop_cnt, 250);
    drain();
    tx_ready = 0;
    base = sent.size();
    for (int i = 0; i < 4; i++) retire(32'h30 * i, 0, 0, 0);
    for (int i = 0; i < 50; i++) retire(32'h20, 0, 0, 0);
    chk("t5_drop_sat", drop_cnt, 255);
    chk("t5_overflow", overflow, 1);
    drain();
    chk("t5_seq_fe", sent[base+23], 8'hFE);
    chk("t5_seq_ff", sent[base+47], 8'hFF);
    chk("t5_seq_00", sent[base+71], 8'h00);
    chk("t5_seq_01", sent[base+95], 8'h01);

    // reset mid-packet
    do_reset();
    tx_ready = 1;
    retire(32'hA000, 7, 8, 9);
    retire(32'hB000, 7, 8, 9);
    base = sent.size();
    n = 0;
    while (sent.size() - base < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach10", sent.size() - base, 10);
    rst = 1;
    #1;
    chk("t6_valid_rst", tx_valid, 0);
    chk("t6_data_rst", tx_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    base = sent.size();
    repeat (40) @(negedge clk);
    chk("t6_no_resume", sent.size() - base, 0);
    chk("t6_valid_idle", tx_valid, 0);
    retire(32'hC000, 1, 1, 1);
    drain();
    chk("t6_new_pkt", sent.size() - base, 24);
    chk("t6_new_seq", sent[base+23], 8'h00);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/rvfi_pkt_serializer.md
RVFI_PKT_SERIALIZER -- requirements
Module: rvfi_pkt_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning packet FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ret_valid, input, 1, one instruction retires this cycle.
REQ-005 SHALL have ports ret_pc, ret_nxt_pc and ret_instr, input, 32 each, retiring PC, next PC including trap redirect, and instruction word.
REQ-006 SHALL have ports ret_rd_val and ret_mem_addr, input, 32 each, rd writeback value and memory address.
REQ-007 SHALL have port ret_rd, input, 5, rd index.
REQ-008 SHALL have port ret_trap, input, 1, retiring instruction trapped.
REQ-009 SHALL have ports ret_mem_rmask and ret_mem_wmask, input, 4 each, byte read and write masks.
REQ-010 SHALL have ports tx_valid (output, 1), tx_ready (input, 1), tx_data (output, 8) and tx_last (output, 1), forming the byte stream to the host.
REQ-011 SHALL have port fifo_full, output, 1, all DEPTH entries occupied; used by the harness to hold the core.
REQ-012 SHALL have port overflow, output, 1, sticky flag set when a retirement is dropped.
REQ-013 SHALL have port drop_cnt, output, 8, count of dropped retirements, saturating.

Function
REQ-014 SHALL push one entry per cycle when ret_valid=1 and (count<DEPTH or a pop occurs in the same cycle).
REQ-015 SHALL drop the retirement when ret_valid=1, count==DEPTH and no pop occurs that cycle: overflow<=1, drop_cnt<=min(drop_cnt+1,255).
REQ-016 SHALL keep an 8-bit seq counter that increments on every ret_valid, accepted or dropped, wrapping 255->0; the pre-increment value is stored in the entry.
REQ-017 SHALL serialize each entry as 24 bytes, in order: byte0=0xA5; pc; nxt_pc; instr; rd_val; mem_addr; byte21={ret_trap,2'b00,ret_rd}; byte22={wmask,rmask}; byte23=seq.
REQ-018 SHALL send every 32-bit field little-endian, least-significant byte first.
REQ-019 SHALL use an FSM with states IDLE and SEND.
REQ-020 In IDLE, the FSM SHALL move to SEND when count>0, with byte index=0.
REQ-021 In SEND, a byte SHALL transfer only when tx_valid and tx_ready are both 1; the byte index then increments.
REQ-022 On the transfer of byte 23, the FSM SHALL pop the head entry and go to SEND again if count after the pop is >0, otherwise to IDLE; there SHALL be no idle gap between back-to-back packets.
REQ-023 tx_valid SHALL equal (state==SEND); tx_data SHALL be stable while tx_valid=1 and tx_ready=0; tx_last SHALL be 1 only for byte 23.
REQ-024 An entry pushed in cycle N SHALL appear as byte0 on tx_data no earlier than cycle N+1 (FIFO empty, IDLE).
REQ-025 fifo_full SHALL be registered and equal (count==DEPTH).
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-027 The head entry SHALL not be modified while it is being sent.

Reset
REQ-028 On rst, the block SHALL set state=IDLE, count=0, pointers=0, byte index=0 and seq=0.
REQ-029 On rst, the outputs SHALL be tx_valid=0, tx_data=0, tx_last=0, fifo_full=0, overflow=0, drop_cnt=0.
REQ-030 Reset asserted mid-packet SHALL abort the packet; no partial packet SHALL resume after reset.

Verification
REQ-031 Single retire, pc=0x80000000, instr=0x00500093, rd=1, rd_val=5, tx_ready=1 -> 24 consecutive bytes starting A5 00 00 00 80; byte21=0x01, byte23=0x00, tx_last on byte 23.
REQ-032 tx_ready toggled 1,0,0,1 during a packet -> no byte duplicated or skipped; tx_data held during the stalls.
REQ-033 DEPTH=4, tx_ready=0, 6 retires -> fifo_full=1 after 4 pushes; overflow=1, drop_cnt=2; the seq values sent are 0..3.
REQ-034 Full FIFO and a retire in the same cycle as the byte-23 pop -> retire accepted, drop_cnt unchanged, count stays 4.
REQ-035 300 dropped retirements -> drop_cnt saturates at 255; the seq field wraps and is seen as 0x00 after 0xFF.
REQ-036 rst asserted at byte 10 with 2 entries queued -> tx_valid=0 immediately; after release, no bytes are sent until the next retire.
